// File: rtl/dbg_apb_core_slave_if.sv
// APB slave bus plus core debug/memory port for dbg_apb_core_slave.
// The slave modport is the DUT side; master is the bridge/core side.
interface dbg_apb_core_slave_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  apb_sel;
    logic                  apb_enable;
    logic                  apb_wr_rd;
    logic [ADDR_WIDTH-1:0] apb_addr;
    logic [DATA_WIDTH-1:0] apb_wdata;
    logic [3:0]            apb_wstrobe;
    logic                  apb_ready;
    logic [DATA_WIDTH-1:0] apb_rdata;
    logic                  core_halt_req;
    logic                  core_resume_req;
    logic                  core_halted;
    logic                  mem_req;
    logic                  mem_we;
    logic [31:0]           mem_addr;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_wstrobe;
    logic                  mem_ack;
    logic [31:0]           mem_rdata;

    modport slave (
        input  apb_sel, apb_enable, apb_wr_rd, apb_addr, apb_wdata, apb_wstrobe,
        output apb_ready, apb_rdata,
        output core_halt_req, core_resume_req,
        input  core_halted,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrobe,
        input  mem_ack, mem_rdata
    );

    modport master (
        output apb_sel, apb_enable, apb_wr_rd, apb_addr, apb_wdata, apb_wstrobe,
        input  apb_ready, apb_rdata,
        input  core_halt_req, core_resume_req,
        output core_halted,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrobe,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/dbg_apb_core_slave.sv
// Debug APB slave: control/status registers and a single-outstanding core memory port.
// Optional mem_ack timeout with sticky err enabled by DBG_APB_SLV_TIMEOUT_EN.
module dbg_apb_core_slave #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned WAIT_STATES    = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dbg_apb_core_slave_if.slave   bus
);
    localparam logic [2:0] RegCtrl   = 3'd0;
    localparam logic [2:0] RegStatus = 3'd1;
    localparam logic [2:0] RegAddr   = 3'd2;
    localparam logic [2:0] RegWdata  = 3'd3;
    localparam logic [2:0] RegRdata  = 3'd4;
    localparam logic [2:0] RegCmd    = 3'd5;

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    state_e      r_state, w_state_d;
    logic [3:0]  r_wait_cnt;
    logic        r_halt;
    logic        r_resume;
    logic [31:0] r_mem_addr_reg;
    logic [31:0] r_mem_wdata_reg;
    logic [31:0] r_mem_rdata_reg;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wstrobe;

    logic [2:0]            w_idx;
    logic                  w_access;
    logic                  w_wait_done;
    logic                  w_stall_reg;
    logic                  w_busy;
    logic                  w_ready;
    logic                  w_wr;
    logic                  w_lane0_wr;
    logic                  w_launch;
    logic                  w_err_clr;
    logic                  w_timeout;
    logic                  w_err;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_unused_addr;

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        end
        return res;
    endfunction

    assign w_idx         = bus.apb_addr[4:2];
    assign w_unused_addr = ^{bus.apb_addr[ADDR_WIDTH-1:5], bus.apb_addr[1:0]};
    assign w_access      = bus.apb_sel & bus.apb_enable;
    assign w_wait_done   = (r_wait_cnt == 4'(WAIT_STATES));
    assign w_stall_reg   = (w_idx >= RegAddr) && (w_idx <= RegCmd);
    assign w_busy        = (r_state == StReq);
    // rst_n gating keeps ready/rdata low during reset without waiting for a clock.
    assign w_ready       = rst_n & w_access & w_wait_done & ~(w_busy & w_stall_reg);
    assign w_wr          = w_ready & bus.apb_wr_rd;
    assign w_lane0_wr    = w_wr & bus.apb_wstrobe[0];
    assign w_launch      = w_lane0_wr & (w_idx == RegCmd) & (|bus.apb_wdata[1:0]) & ~w_busy;
    assign w_err_clr     = w_lane0_wr & (w_idx == RegStatus) & bus.apb_wdata[2];

    always_comb begin
        w_rdata = '0;
        case (w_idx)
            RegCtrl:   w_rdata = {31'b0, r_halt};
            RegStatus: w_rdata = {29'b0, w_err, w_busy, bus.core_halted};
            RegAddr:   w_rdata = r_mem_addr_reg;
            RegWdata:  w_rdata = r_mem_wdata_reg;
            RegRdata:  w_rdata = r_mem_rdata_reg;
            RegCmd:    w_rdata = {31'b0, w_busy};
            default:   w_rdata = '0;
        endcase
    end

    assign bus.apb_ready       = w_ready;
    assign bus.apb_rdata       = w_ready ? w_rdata : '0;
    assign bus.core_halt_req   = r_halt;
    assign bus.core_resume_req = r_resume;
    assign bus.mem_req         = w_busy;
    assign bus.mem_we          = r_mem_we;
    assign bus.mem_addr        = r_mem_addr;
    assign bus.mem_wdata       = r_mem_wdata;
    assign bus.mem_wstrobe     = r_mem_wstrobe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (!bus.apb_sel || w_ready) begin
            r_wait_cnt <= '0;
        end else if (w_access && !w_wait_done) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halt          <= 1'b0;
            r_resume        <= 1'b0;
            r_mem_addr_reg  <= '0;
            r_mem_wdata_reg <= '0;
            r_mem_rdata_reg <= '0;
        end else begin
            r_resume <= w_lane0_wr && (w_idx == RegCtrl) && bus.apb_wdata[1];
            if (w_lane0_wr && (w_idx == RegCtrl)) begin
                r_halt <= bus.apb_wdata[0];
            end
            if (w_wr && (w_idx == RegAddr)) begin
                r_mem_addr_reg <= merge(r_mem_addr_reg, bus.apb_wdata, bus.apb_wstrobe);
            end
            if (w_wr && (w_idx == RegWdata)) begin
                r_mem_wdata_reg <= merge(r_mem_wdata_reg, bus.apb_wdata, bus.apb_wstrobe);
            end
            if (w_busy && bus.mem_ack && !r_mem_we) begin
                r_mem_rdata_reg <= bus.mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:  if (w_launch) w_state_d = StReq;
            StReq:   if (bus.mem_ack || w_timeout) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Command outputs are latched on launch and held stable through REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_mem_wstrobe <= '0;
        end else if (w_launch) begin
            r_mem_we      <= ~bus.apb_wdata[0];
            r_mem_addr    <= r_mem_addr_reg;
            r_mem_wdata   <= r_mem_wdata_reg;
            r_mem_wstrobe <= 4'hF;
        end
    end

`ifdef DBG_APB_SLV_TIMEOUT_EN
    logic [31:0] r_to_cnt;
    logic        r_err;

    // An ack on the final cycle wins over the timeout.
    assign w_timeout = w_busy && !bus.mem_ack && (r_to_cnt == TIMEOUT_CYCLES - 1);
    assign w_err     = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            r_to_cnt <= w_busy ? r_to_cnt + 32'd1 : '0;
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (w_err_clr) begin
                r_err <= 1'b0;
            end
        end
    end
`else
    logic [31:0] w_unused_to;
    logic        w_unused_clr;

    assign w_timeout    = 1'b0;
    assign w_err        = 1'b0;
    assign w_unused_to  = TIMEOUT_CYCLES;
    assign w_unused_clr = w_err_clr;
`endif

endmodule

// File: tb/tb_dbg_apb_core_slave.sv
// Directed self-checking bench for dbg_apb_core_slave (WAIT_STATES 0 and 3 instances).
// Timeout checks are compiled in only when DBG_APB_SLV_TIMEOUT_EN is defined.
module tb_dbg_apb_core_slave;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    bit          ack_en;
    int          ack_dly;
    int          ack_cnt;
    logic [31:0] ack_data;

    dbg_apb_core_slave_if bus0 ();
    dbg_apb_core_slave_if bus1 ();

    dbg_apb_core_slave #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .WAIT_STATES    (0),
        .TIMEOUT_CYCLES (8)
    ) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    dbg_apb_core_slave #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .WAIT_STATES    (3),
        .TIMEOUT_CYCLES (8)
    ) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts at posedge+1, returns at posedge+1 after the completion edge.
    task automatic apb(input int which, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       output logic [31:0] rdata, output int waits, output bit leak);
        rdata = '0;
        waits = 0;
        leak  = 1'b0;
        bus0.apb_sel = (which == 0);
        bus1.apb_sel = (which == 1);
        bus0.apb_enable = 1'b0;  bus1.apb_enable = 1'b0;
        bus0.apb_wr_rd = wr;     bus1.apb_wr_rd = wr;
        bus0.apb_addr = addr;    bus1.apb_addr = addr;
        bus0.apb_wdata = wdata;  bus1.apb_wdata = wdata;
        bus0.apb_wstrobe = strb; bus1.apb_wstrobe = strb;
        @(posedge clk); #1;
        bus0.apb_enable = 1'b1;  bus1.apb_enable = 1'b1;
        forever begin
            @(negedge clk);
            if ((which == 0) ? bus0.apb_ready : bus1.apb_ready) begin
                rdata = (which == 0) ? bus0.apb_rdata : bus1.apb_rdata;
                break;
            end
            if (((which == 0) ? bus0.apb_rdata : bus1.apb_rdata) !== '0) leak = 1'b1;
            waits++;
            if (waits >= 100) begin
                n_tests++;
                n_fail++;
                $error("FAIL apb_ready_bound: got no ready after %0d cycles expected ready", waits);
                break;
            end
        end
        @(posedge clk); #1;
        bus0.apb_sel = 1'b0;    bus1.apb_sel = 1'b0;
        bus0.apb_enable = 1'b0; bus1.apb_enable = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus0.mem_req && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, {31'b0, bus0.mem_req}, 32'h0);
    endtask

    // Core model: acks ack_dly cycles after mem_req rises.
    initial begin
        ack_cnt = 0;
        bus0.mem_ack = 1'b0;
        bus0.mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            bus0.mem_ack = 1'b0;
            if (bus0.mem_req && ack_en) begin
                ack_cnt++;
                if (ack_cnt == ack_dly) begin
                    bus0.mem_ack   = 1'b1;
                    bus0.mem_rdata = ack_data;
                    ack_cnt        = 0;
                end
            end else begin
                ack_cnt = 0;
            end
        end
    end

    initial begin
        logic [31:0] rd;
        int          w;
        bit          lk;
        n_tests = 0;
        n_fail  = 0;
        ack_en  = 1'b0;
        ack_dly = 5;
        ack_data = '0;
        rst_n = 1'b0;
        bus0.apb_sel = 0; bus0.apb_enable = 0; bus0.apb_wr_rd = 0;
        bus0.apb_addr = '0; bus0.apb_wdata = '0; bus0.apb_wstrobe = '0;
        bus0.core_halted = 1'b0;
        bus1.apb_sel = 0; bus1.apb_enable = 0; bus1.apb_wr_rd = 0;
        bus1.apb_addr = '0; bus1.apb_wdata = '0; bus1.apb_wstrobe = '0;
        bus1.core_halted = 1'b1;
        bus1.mem_ack = 1'b0; bus1.mem_rdata = '0;

        #3;
        chk("rst_ready", {31'b0, bus0.apb_ready}, 32'h0);
        chk("rst_rdata", bus0.apb_rdata, 32'h0);
        chk("rst_mem_req", {31'b0, bus0.mem_req}, 32'h0);
        chk("rst_halt", {31'b0, bus0.core_halt_req}, 32'h0);
        chk("rst_resume", {31'b0, bus0.core_resume_req}, 32'h0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // CTRL halt write/read, zero wait states
        apb(0, 1, 32'h00, 32'h1, 4'hF, rd, w, lk);
        chk("ctrl_wr_waits", w, 0);
        chk("halt_req", {31'b0, bus0.core_halt_req}, 32'h1);
        apb(0, 0, 32'h00, 32'h0, 4'h0, rd, w, lk);
        chk("ctrl_rd", rd, 32'h1);
        chk("ctrl_rd_waits", w, 0);

        // RESUME pulse lasts exactly one cycle and reads back 0
        apb(0, 1, 32'h00, 32'h3, 4'h1, rd, w, lk);
        chk("resume_pulse", {31'b0, bus0.core_resume_req}, 32'h1);
        apb(0, 0, 32'h00, 32'h0, 4'h0, rd, w, lk);
        chk("resume_gone", {31'b0, bus0.core_resume_req}, 32'h0);
        chk("ctrl_rd_after_resume", rd, 32'h1);

        // Memory read: status not stalled, MEM_RDATA stalled for the whole REQ
        ack_en = 1'b1; ack_dly = 5; ack_data = 32'hDEADBEEF;
        apb(0, 1, 32'h08, 32'h1000, 4'hF, rd, w, lk);
        apb(0, 1, 32'h14, 32'h1, 4'hF, rd, w, lk);
        chk("rd_mem_req", {31'b0, bus0.mem_req}, 32'h1);
        chk("rd_mem_we", {31'b0, bus0.mem_we}, 32'h0);
        chk("rd_mem_addr", bus0.mem_addr, 32'h1000);
        chk("rd_mem_strb", {28'b0, bus0.mem_wstrobe}, 32'hF);
        apb(0, 0, 32'h04, 32'h0, 4'h0, rd, w, lk);
        chk("status_busy", rd, 32'h2);
        chk("status_no_stall", w, 0);
        apb(0, 0, 32'h10, 32'h0, 4'h0, rd, w, lk);
        chk("rdata_stalled", {31'b0, w > 0}, 32'h1);
        chk("rdata_val", rd, 32'hDEADBEEF);
        chk("rdata_no_leak", {31'b0, lk}, 32'h0);
        apb(0, 0, 32'h04, 32'h0, 4'h0, rd, w, lk);
        chk("status_idle", rd, 32'h0);

        // Strobed write of MEM_WDATA over 0
        apb(0, 1, 32'h0C, 32'h11223344, 4'b0101, rd, w, lk);
        apb(0, 0, 32'h0C, 32'h0, 4'h0, rd, w, lk);
        chk("wdata_strobe", rd, 32'h00220044);

        // Memory write leaves MEM_RDATA untouched
        ack_data = 32'h12345678;
        apb(0, 1, 32'h14, 32'h2, 4'h1, rd, w, lk);
        chk("wr_mem_we", {31'b0, bus0.mem_we}, 32'h1);
        chk("wr_mem_wdata", bus0.mem_wdata, 32'h00220044);
        wait_idle("wr_done");
        apb(0, 0, 32'h10, 32'h0, 4'h0, rd, w, lk);
        chk("rdata_kept", rd, 32'hDEADBEEF);

        // Both command bits: read wins
        ack_data = 32'hCAFEF00D;
        apb(0, 1, 32'h14, 32'h3, 4'h1, rd, w, lk);
        chk("both_we", {31'b0, bus0.mem_we}, 32'h0);
        apb(0, 0, 32'h10, 32'h0, 4'h0, rd, w, lk);
        chk("both_rdata", rd, 32'hCAFEF00D);

        // Unmapped register and idle MEM_CMD read
        apb(0, 1, 32'h18, 32'hFFFFFFFF, 4'hF, rd, w, lk);
        apb(0, 0, 32'h18, 32'h0, 4'h0, rd, w, lk);
        chk("reg6_zero", rd, 32'h0);
        apb(0, 0, 32'h14, 32'h0, 4'h0, rd, w, lk);
        chk("cmd_idle", rd, 32'h0);

        // Three wait states on the second instance
        apb(1, 0, 32'h04, 32'h0, 4'h0, rd, w, lk);
        chk("ws3_waits", w, 3);
        chk("ws3_status", rd, 32'h1);
        chk("ws3_no_leak", {31'b0, lk}, 32'h0);

`ifdef DBG_APB_SLV_TIMEOUT_EN
        begin
            int n;
            ack_en = 1'b0;
            apb(0, 1, 32'h14, 32'h1, 4'h1, rd, w, lk);
            n = 0;
            while (bus0.mem_req && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            chk("to_cycles", n, 8);
            apb(0, 0, 32'h04, 32'h0, 4'h0, rd, w, lk);
            chk("to_err", rd, 32'h4);
            apb(0, 1, 32'h04, 32'h4, 4'h1, rd, w, lk);
            apb(0, 0, 32'h04, 32'h0, 4'h0, rd, w, lk);
            chk("to_err_clr", rd, 32'h0);
            apb(0, 0, 32'h10, 32'h0, 4'h0, rd, w, lk);
            chk("to_rdata_kept", rd, 32'hCAFEF00D);
        end
`endif

        // Asynchronous reset during REQ
        ack_en = 1'b0;
        apb(0, 1, 32'h14, 32'h1, 4'h1, rd, w, lk);
        chk("pre_rst_req", {31'b0, bus0.mem_req}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_mem_req", {31'b0, bus0.mem_req}, 32'h0);
        chk("async_mem_addr", bus0.mem_addr, 32'h0);
        chk("async_halt", {31'b0, bus0.core_halt_req}, 32'h0);
        chk("async_strb", {28'b0, bus0.mem_wstrobe}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        apb(0, 0, 32'h04, 32'h0, 4'h0, rd, w, lk);
        chk("post_rst_status", rd, 32'h0);
        apb(0, 0, 32'h08, 32'h0, 4'h0, rd, w, lk);
        chk("post_rst_addr", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
